act_sched: RTL and testbench

ACT_SCHED -- requirements
Module: act_sched

---
 rtl/act_pkg.sv | 22 ++
 rtl/act_sched_if.sv | 25 ++
 rtl/act_idx_counter.sv | 64 ++++++
 rtl/act_sched.sv | 168 ++++++++++++++++
 tb/tb_act_sched.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/act_pkg.sv
// Shared types and default sizing for the activation scheduler.
package act_pkg;

  localparam int unsigned H_MAX_DEF  = 256;
  localparam int unsigned W_MAX_DEF  = 256;
  localparam int unsigned NF_MAX_DEF = 64;
  localparam int unsigned DP_LAT_DEF = 3;

  // Dimension widths: cfg fields hold counts, index fields hold count-1
  localparam int unsigned H_DW_DEF   = $clog2(H_MAX_DEF + 1);
  localparam int unsigned W_DW_DEF   = $clog2(W_MAX_DEF + 1);
  localparam int unsigned NF_DW_DEF  = $clog2(NF_MAX_DEF + 1);
  localparam int unsigned IDX_W_DEF  = $clog2(NF_MAX_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_state_t;

endpackage

// File: rtl/act_sched_if.sv
// Element stream between upstream source, activation datapath and downstream sink.
interface act_sched_if #(
  parameter int unsigned NF_MAX = act_pkg::NF_MAX_DEF
);
  localparam int unsigned IDX_W = $clog2(NF_MAX);

  logic             in_valid;
  logic             in_ready;
  logic             dp_ce;
  logic             dp_issue;
  logic [IDX_W-1:0] dp_filter_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  in_valid, out_ready,
    output in_ready, dp_ce, dp_issue, dp_filter_idx, out_valid, out_last
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, dp_ce, dp_issue, dp_filter_idx, out_valid, out_last
  );
endinterface

// File: rtl/act_idx_counter.sv
// Nested row/column/filter element counter; filter runs fastest, then column, then row.
module act_idx_counter
  import act_pkg::*;
#(
  parameter int unsigned H_MAX  = H_MAX_DEF,
  parameter int unsigned W_MAX  = W_MAX_DEF,
  parameter int unsigned NF_MAX = NF_MAX_DEF,
  localparam int unsigned H_DW  = $clog2(H_MAX + 1),
  localparam int unsigned W_DW  = $clog2(W_MAX + 1),
  localparam int unsigned NF_DW = $clog2(NF_MAX + 1),
  localparam int unsigned HI_W  = $clog2(H_MAX),
  localparam int unsigned WI_W  = $clog2(W_MAX),
  localparam int unsigned FI_W  = $clog2(NF_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [H_DW-1:0]  bound_h,
  input  logic [W_DW-1:0]  bound_w,
  input  logic [NF_DW-1:0] bound_nf,
  output logic [HI_W-1:0]  row_idx,
  output logic [WI_W-1:0]  col_idx,
  output logic [FI_W-1:0]  filt_idx,
  output logic             last
);

  logic [HI_W-1:0] r_row;
  logic [WI_W-1:0] r_col;
  logic [FI_W-1:0] r_filt;
  logic            w_f_wrap;
  logic            w_c_wrap;
  logic            w_r_wrap;

  assign w_f_wrap = (NF_DW'(r_filt) == (bound_nf - NF_DW'(1)));
  assign w_c_wrap = (W_DW'(r_col)   == (bound_w  - W_DW'(1)));
  assign w_r_wrap = (H_DW'(r_row)   == (bound_h  - H_DW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_row  <= '0;
      r_col  <= '0;
      r_filt <= '0;
    end else if (step) begin
      if (w_f_wrap) begin
        r_filt <= '0;
        if (w_c_wrap) begin
          r_col <= '0;
          r_row <= w_r_wrap ? '0 : r_row + HI_W'(1);
        end else begin
          r_col <= r_col + WI_W'(1);
        end
      end else begin
        r_filt <= r_filt + FI_W'(1);
      end
    end
  end

  assign row_idx  = r_row;
  assign col_idx  = r_col;
  assign filt_idx = r_filt;
  assign last     = w_f_wrap & w_c_wrap & w_r_wrap;

endmodule

// File: rtl/act_sched.sv
// Activation-layer scheduler: walks an H x W x NF tensor and tracks results through the datapath.
// Optional ACT_SCHED_PERF_EN adds stall/busy performance counters.
module act_sched
  import act_pkg::*;
#(
  parameter int unsigned H_MAX  = H_MAX_DEF,
  parameter int unsigned W_MAX  = W_MAX_DEF,
  parameter int unsigned NF_MAX = NF_MAX_DEF,
  parameter int unsigned DP_LAT = DP_LAT_DEF,
  localparam int unsigned H_DW  = $clog2(H_MAX + 1),
  localparam int unsigned W_DW  = $clog2(W_MAX + 1),
  localparam int unsigned NF_DW = $clog2(NF_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [H_DW-1:0]  cfg_h,
  input  logic [W_DW-1:0]  cfg_w,
  input  logic [NF_DW-1:0] cfg_nf,
  output logic             busy,
  output logic             done,
  act_sched_if.master      stream
`ifdef ACT_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_busy_cnt
`endif
);

  localparam int unsigned HI_W = $clog2(H_MAX);
  localparam int unsigned WI_W = $clog2(W_MAX);
  localparam int unsigned FI_W = $clog2(NF_MAX);

  act_state_t         r_state;
  logic [H_DW-1:0]    r_h;
  logic [W_DW-1:0]    r_w;
  logic [NF_DW-1:0]   r_nf;
  logic               r_busy;
  logic               r_done;
  logic [DP_LAT-1:0]  r_tag_v;
  logic [DP_LAT-1:0]  r_tag_l;

  logic               w_start;
  logic               w_zero;
  logic               w_dp_ce;
  logic               w_in_ready;
  logic               w_issue;
  logic               w_last;
  logic               w_accept_last;
  logic [HI_W-1:0]    w_row;
  logic [WI_W-1:0]    w_col;
  logic [FI_W-1:0]    w_fidx;

  // Only a held result at the output can stall; everything behind it freezes together
  assign w_dp_ce       = ~(r_tag_v[DP_LAT-1] & ~stream.out_ready);
  assign w_in_ready    = (r_state == RUN) & w_dp_ce;
  assign w_issue       = stream.in_valid & w_in_ready;
  assign w_start       = start & (r_state == IDLE);
  assign w_zero        = (cfg_h == '0) | (cfg_w == '0) | (cfg_nf == '0);
  assign w_accept_last = r_tag_v[DP_LAT-1] & r_tag_l[DP_LAT-1] & stream.out_ready;

  act_idx_counter #(
    .H_MAX  (H_MAX),
    .W_MAX  (W_MAX),
    .NF_MAX (NF_MAX)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start),
    .step     (w_issue),
    .bound_h  (r_h),
    .bound_w  (r_w),
    .bound_nf (r_nf),
    .row_idx  (w_row),
    .col_idx  (w_col),
    .filt_idx (w_fidx),
    .last     (w_last)
  );

  // Pass control; cfg is captured only on an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_h     <= '0;
      r_w     <= '0;
      r_nf    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_h  <= cfg_h;
            r_w  <= cfg_w;
            r_nf <= cfg_nf;
            if (w_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue && w_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_accept_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid/last tags shadow the datapath pipeline stage for stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      r_tag_l <= '0;
    end else if (w_dp_ce) begin
      for (int i = int'(DP_LAT) - 1; i > 0; i--) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_l[i] <= r_tag_l[i-1];
      end
      r_tag_v[0] <= w_issue;
      r_tag_l[0] <= w_issue & w_last;
    end
  end

  a_idx_in_bounds: assert property (@(posedge clk) disable iff (!rst_n)
    r_busy |-> ((H_DW'(w_row) < r_h) && (W_DW'(w_col) < r_w) && (NF_DW'(w_fidx) < r_nf)));

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign stream.in_ready      = w_in_ready;
  assign stream.dp_ce         = w_dp_ce;
  assign stream.dp_issue      = w_issue;
  assign stream.dp_filter_idx = w_fidx;
  assign stream.out_valid     = r_tag_v[DP_LAT-1];
  assign stream.out_last      = r_tag_l[DP_LAT-1];

`ifdef ACT_SCHED_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_busy;

  // Saturating event counters, restarted with each accepted pass
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_perf_stall <= '0;
      r_perf_busy  <= '0;
    end else begin
      if (!w_dp_ce && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (r_busy && (r_perf_busy != '1))    r_perf_busy  <= r_perf_busy + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_busy_cnt  = r_perf_busy;
`endif

endmodule

// File: tb/tb_act_sched.sv
// Directed bench for act_sched: per-cycle vector table plus multi-cycle pass sequences.
module tb_act_sched;

  localparam int unsigned H_DW  = 9;
  localparam int unsigned W_DW  = 9;
  localparam int unsigned NF_DW = 7;
  localparam int unsigned IDX_W = 6;
  localparam int          LAT   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [H_DW-1:0]  cfg_h;
  logic [W_DW-1:0]  cfg_w;
  logic [NF_DW-1:0] cfg_nf;
  logic             busy;
  logic             done;
`ifdef ACT_SCHED_PERF_EN
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_busy_cnt;
`endif

  act_sched_if #(.NF_MAX(64)) bus ();

  act_sched dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cfg_h  (cfg_h),
    .cfg_w  (cfg_w),
    .cfg_nf (cfg_nf),
    .busy   (busy),
    .done   (done),
    .stream (bus)
`ifdef ACT_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_busy_cnt  (perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit st; int h; int w; int nf; bit iv; bit ordy;
    bit e_busy; bit e_done; bit e_inr; bit e_iss; int e_fidx; bit e_ov; bit e_ol; bit e_ce;
  } vec_t;

  function automatic vec_t mk(bit st, int h, int w, int nf, bit iv, bit ordy,
                              bit e_busy, bit e_done, bit e_inr, bit e_iss, int e_fidx,
                              bit e_ov, bit e_ol, bit e_ce);
    vec_t v;
    v.st = st; v.h = h; v.w = w; v.nf = nf; v.iv = iv; v.ordy = ordy;
    v.e_busy = e_busy; v.e_done = e_done; v.e_inr = e_inr; v.e_iss = e_iss;
    v.e_fidx = e_fidx; v.e_ov = e_ov; v.e_ol = e_ol; v.e_ce = e_ce;
    return v;
  endfunction

  // Drive one full pass with in_valid held high; out_ready dropped for [st_at, st_at+st_len)
  task automatic run_pass(input string nm, input int h, input int w, input int nf,
                          input int st_at, input int st_len, input int exp_stall, input bit poke);
    int total, n_iss, n_res, cyc, n_stall, last_acc, t_i, s_i;
    bit done_seen;
    int iss_cyc[$];
    int iss_stl[$];
    total = h * w * nf; n_iss = 0; n_res = 0; cyc = 0; n_stall = 0; last_acc = -100;
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_h = H_DW'(h); cfg_w = W_DW'(w); cfg_nf = NF_DW'(nf);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " idle_in_ready"}, 32'(bus.in_ready), 0);
    while (!done_seen && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 3);
      if (poke && cyc >= 3) begin cfg_h = 1; cfg_w = 1; cfg_nf = 1; end
      bus.out_ready = !(cyc >= st_at && cyc < st_at + st_len);
      @(negedge clk);
      chk({nm, " dp_ce"}, 32'(bus.dp_ce), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        chk({nm, " stall_in_ready"}, 32'(bus.in_ready), 0);
      end
      if (bus.dp_issue) begin
        chk({nm, " filter_idx"}, 32'(bus.dp_filter_idx), 32'(n_iss % nf));
        iss_cyc.push_back(cyc);
        iss_stl.push_back(n_stall);
        n_iss++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk({nm, " out_last"}, 32'(bus.out_last), 32'(n_res == total - 1));
        if (iss_cyc.size() == 0) begin
          chk({nm, " result_without_issue"}, 1, 0);
        end else begin
          t_i = iss_cyc.pop_front();
          s_i = iss_stl.pop_front();
          chk({nm, " latency"}, 32'(cyc - t_i), 32'(LAT + n_stall - s_i));
        end
        n_res++;
        last_acc = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({nm, " done_after_last"}, 32'(cyc), 32'(last_acc + 1));
        chk({nm, " busy_at_done"}, 32'(busy), 0);
      end
    end
    if (!done_seen) chk({nm, " done_timeout"}, 0, 1);
    chk({nm, " issues"}, 32'(n_iss), 32'(total));
    chk({nm, " results"}, 32'(n_res), 32'(total));
    chk({nm, " stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, " done_one_cycle"}, 32'(done), 0);
  endtask

  vec_t vt[$];

  initial begin
    int n;
    int cyc;
    rst_n = 1'b0; start = 1'b0; cfg_h = '0; cfg_w = '0; cfg_nf = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_last", 32'(bus.out_last), 0);
    chk("rst dp_ce", 32'(bus.dp_ce), 1);

    // 1x1x1 pass, start during DONE, then a zero-filter pass
    //          st h w nf iv or | busy done inr iss fidx ov ol ce
    vt.push_back(mk(1, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 1, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 1, 1, 1));
    vt.push_back(mk(1, 1, 1, 1, 1, 1,  0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 2, 2, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 2, 2, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 2, 2, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      start = vt[i].st; cfg_h = H_DW'(vt[i].h); cfg_w = W_DW'(vt[i].w); cfg_nf = NF_DW'(vt[i].nf);
      bus.in_valid = vt[i].iv; bus.out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_inr));
      chk($sformatf("vec%0d dp_issue", i), 32'(bus.dp_issue), 32'(vt[i].e_iss));
      if (vt[i].e_iss) chk($sformatf("vec%0d fidx", i), 32'(bus.dp_filter_idx), 32'(vt[i].e_fidx));
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d out_last", i), 32'(bus.out_last), 32'(vt[i].e_ol));
      chk($sformatf("vec%0d dp_ce", i), 32'(bus.dp_ce), 32'(vt[i].e_ce));
    end

    run_pass("p223", 2, 2, 3, 0, 0, 0, 1'b0);
    run_pass("p124_stall", 1, 2, 4, 5, 5, 5, 1'b0);
    run_pass("p223_restart", 2, 2, 3, 0, 0, 0, 1'b1);

    // Reset after 5 of 16 issues
    @(posedge clk); #1;
    start = 1'b1; cfg_h = 4; cfg_w = 2; cfg_nf = 2;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    n = 0; cyc = 0;
    while (n < 5 && cyc < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (bus.dp_issue) n++;
      cyc++;
    end
    chk("mid_rst issues_before", 32'(n), 5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst busy", 32'(busy), 0);
    chk("mid_rst done", 32'(done), 0);
    chk("mid_rst in_ready", 32'(bus.in_ready), 0);
    chk("mid_rst dp_issue", 32'(bus.dp_issue), 0);
    chk("mid_rst out_last", 32'(bus.out_last), 0);
    chk("mid_rst dp_ce", 32'(bus.dp_ce), 1);
    for (int k = 0; k < 8; k++) begin
      chk("mid_rst out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst in_ready_hold", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    run_pass("p111_after_rst", 1, 1, 1, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
